// File: rtl/fft_control_if.sv
// Control bundle between the FFT sequencer and the sample source, address
// generator, butterfly datapath and result consumer.
interface fft_control_if;
  logic       start;
  logic       sample_valid;
  logic       out_ready;
  logic       load;
  logic       processing;
  logic       done;
  logic       load_we;
  logic [5:0] load_address;
  logic [5:0] fft_level;
  logic [5:0] butterfly_iter;
  logic [5:0] wr_butterfly_iter;
  logic [5:0] wr_fft_level;
  logic       bfly_we;
  logic       read_bank;
  logic [5:0] out_address;
  logic       out_valid;
  logic       out_last;

  modport master (
    input  start, sample_valid, out_ready,
    output load, processing, done, load_we, load_address, fft_level,
           butterfly_iter, wr_butterfly_iter, wr_fft_level, bfly_we,
           read_bank, out_address, out_valid, out_last
  );

  modport slave (
    output start, sample_valid, out_ready,
    input  load, processing, done, load_we, load_address, fft_level,
           butterfly_iter, wr_butterfly_iter, wr_fft_level, bfly_we,
           read_bank, out_address, out_valid, out_last
  );
endinterface

// File: rtl/fft_control.sv
// Sequencer for a 64-point radix-2 in-place FFT: sample load, six butterfly
// levels over a ping-pong RAM pair, then result read-out.
module fft_control #(
  parameter int BFLY_LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  fft_control_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, PROC, DRAIN, DONE} state_t;

  typedef struct packed {
    logic       vld;
    logic [5:0] iter;
    logic [5:0] lvl;
  } wr_t;

  localparam logic [2:0] DRAIN_LAST = 3'(BFLY_LATENCY - 1);

  state_t                 state;
  logic [2:0]             drain_cnt;
  logic                   issue;
  wr_t [BFLY_LATENCY:1]   wr_pipe;

  assign issue             = (state == PROC);
  assign bus.load_we       = bus.load & bus.sample_valid;
  assign bus.out_last      = bus.out_valid & (bus.out_address == 6'd63);
  assign bus.bfly_we       = wr_pipe[BFLY_LATENCY].vld;
  assign bus.wr_butterfly_iter = wr_pipe[BFLY_LATENCY].iter;
  assign bus.wr_fft_level  = wr_pipe[BFLY_LATENCY].lvl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      drain_cnt          <= '0;
      wr_pipe            <= '0;
      bus.load           <= 1'b0;
      bus.processing     <= 1'b0;
      bus.done           <= 1'b0;
      bus.out_valid      <= 1'b0;
      bus.load_address   <= '0;
      bus.fft_level      <= '0;
      bus.butterfly_iter <= '0;
      bus.read_bank      <= 1'b0;
      bus.out_address    <= '0;
    end else begin
      // Write side sees zeros between writes so idle outputs stay clean.
      wr_pipe[1] <= {issue, issue ? bus.butterfly_iter : 6'd0,
                     issue ? bus.fft_level : 6'd0};
      for (int i = 2; i <= BFLY_LATENCY; i++) wr_pipe[i] <= wr_pipe[i-1];

      case (state)
        IDLE: if (bus.start) begin
          state            <= LOAD;
          bus.load         <= 1'b1;
          bus.load_address <= '0;
        end
        LOAD: if (bus.sample_valid) begin
          if (bus.load_address == 6'd63) begin
            state              <= PROC;
            bus.load           <= 1'b0;
            bus.load_address   <= '0;
            bus.processing     <= 1'b1;
            bus.fft_level      <= '0;
            bus.butterfly_iter <= '0;
            bus.read_bank      <= 1'b0;
          end else begin
            bus.load_address <= bus.load_address + 6'd1;
          end
        end
        PROC: if (bus.butterfly_iter == 6'd31) begin
          state     <= DRAIN;
          drain_cnt <= '0;
        end else begin
          bus.butterfly_iter <= bus.butterfly_iter + 6'd1;
        end
        // Hold until the final write of this level has left the pipe.
        DRAIN: if (drain_cnt == DRAIN_LAST) begin
          bus.read_bank <= ~bus.read_bank;
          if (bus.fft_level == 6'd5) begin
            state           <= DONE;
            bus.processing  <= 1'b0;
            bus.done        <= 1'b1;
            bus.out_valid   <= 1'b1;
            bus.out_address <= '0;
          end else begin
            state              <= PROC;
            bus.fft_level      <= bus.fft_level + 6'd1;
            bus.butterfly_iter <= '0;
          end
        end else begin
          drain_cnt <= drain_cnt + 3'd1;
        end
        DONE: if (bus.out_ready) begin
          if (bus.out_address == 6'd63) begin
            state              <= IDLE;
            bus.done           <= 1'b0;
            bus.out_valid      <= 1'b0;
            bus.out_address    <= '0;
            bus.fft_level      <= '0;
            bus.butterfly_iter <= '0;
            bus.read_bank      <= 1'b0;
          end else begin
            bus.out_address <= bus.out_address + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_control.sv
// Bench for fft_control: per-cycle comparison against a frame-position model
// (phase + position counter, outputs derived arithmetically).
module tb_fft_control;
  localparam int L        = 2;
  localparam int LVL_CYC  = 32 + L;
  localparam int PROC_CYC = 6 * LVL_CYC;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_control_if bus();
  fft_control #(.BFLY_LATENCY(L)) dut (.clk(clk), .reset(reset), .bus(bus));

  int npass = 0, ntotal = 0, nfail = 0;
  int ph = 0, cnt = 0;            // ph: 0 idle, 1 load, 2 processing, 3 read-out
  int n_load_we, n_proc;
  int bw_lvl [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int lvl, k;
    logic we;
    lvl = (ph == 2) ? cnt / LVL_CYC : 0;
    k   = cnt % LVL_CYC;
    we  = (ph == 2) && (k >= L);
    chk("load",       32'(bus.load),       32'(ph == 1));
    chk("processing", 32'(bus.processing), 32'(ph == 2));
    chk("done",       32'(bus.done),       32'(ph == 3));
    chk("out_valid",  32'(bus.out_valid),  32'(ph == 3));
    chk("load_we",    32'(bus.load_we),    32'(ph == 1 && bus.sample_valid));
    chk("out_last",   32'(bus.out_last),   32'(ph == 3 && cnt == 63));
    chk("bfly_we",    32'(bus.bfly_we),    32'(we));
    chk("wr_iter",    32'(bus.wr_butterfly_iter), we ? k - L : 0);
    chk("wr_level",   32'(bus.wr_fft_level),      we ? lvl : 0);
    chk("read_bank",  32'(bus.read_bank),  32'(lvl % 2));
    if (ph != 3) begin
      chk("fft_level", 32'(bus.fft_level),      lvl);
      chk("bfly_iter", 32'(bus.butterfly_iter), (ph == 2) ? ((k > 31) ? 31 : k) : 0);
    end
    if (ph == 0 || ph == 1) chk("load_address", 32'(bus.load_address), (ph == 1) ? cnt : 0);
    if (ph == 0 || ph == 3) chk("out_address",  32'(bus.out_address),  (ph == 3) ? cnt : 0);
    if (bus.load_we) n_load_we++;
    if (bus.processing) n_proc++;
    if (bus.bfly_we && bus.wr_fft_level < 6) bw_lvl[int'(bus.wr_fft_level)]++;
  endtask

  task automatic advance(input logic r, input logic s, input logic v, input logic o);
    if (r) begin ph = 0; cnt = 0; end
    else case (ph)
      0: if (s) begin ph = 1; cnt = 0; end
      1: if (v) begin if (cnt == 63) begin ph = 2; cnt = 0; end else cnt++; end
      2: if (cnt == PROC_CYC - 1) begin ph = 3; cnt = 0; end else cnt++;
      default: if (o) begin if (cnt == 63) begin ph = 0; cnt = 0; end else cnt++; end
    endcase
  endtask

  task automatic cyc(input logic r, input logic s, input logic v, input logic o);
    reset = r; bus.start = s; bus.sample_valid = v; bus.out_ready = o;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    advance(r, s, v, o);
    #1;
  endtask

  task automatic clear_stats();
    n_load_we = 0; n_proc = 0;
    for (int i = 0; i < 6; i++) bw_lvl[i] = 0;
  endtask

  task automatic check_stats();
    chk("load_we_pulses", n_load_we, 64);
    chk("proc_cycles",    n_proc,    PROC_CYC);
    for (int i = 0; i < 6; i++) chk($sformatf("bfly_we_lvl%0d", i), bw_lvl[i], 32);
  endtask

  // mode 0: clean; 1: toggled sample_valid + stalled read-out;
  // 2: random inputs; 3: start held high throughout
  task automatic run_frame(input int mode);
    int n = 0, t = 0, done_cyc = 0;
    logic started = 1'b0;
    logic s, v, o;
    clear_stats();
    while (!(started && ph == 0) && n < 2000) begin
      case (mode)
        0: begin s = (n == 0); v = 1'b1; o = 1'b1; end
        1: begin s = (n == 0); v = (t % 2 == 0); o = (done_cyc >= 5); end
        2: begin s = 1'($urandom); v = 1'($urandom); o = 1'($urandom); end
        default: begin s = 1'b1; v = 1'b1; o = 1'b1; end
      endcase
      if (ph == 3) done_cyc++;
      if (ph != 0 || s) started = 1'b1;
      cyc(1'b0, s, v, o);
      n++; t++;
    end
    chk("frame_timeout", ph, 0);
    check_stats();
  endtask

  initial begin
    int n;
    reset = 1'b1; bus.start = 1'b0; bus.sample_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(3);

    // Abandon a frame mid-way at level 3, butterfly 10.
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    n = 0;
    while (!(ph == 2 && cnt == 3 * LVL_CYC + 10) && n < 1000) begin
      cyc(1'b0, 1'($urandom), 1'($urandom), 1'b1);
      n++;
    end
    chk("reach_l3_i10", ph, 2);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    run_frame(0);

    for (int i = 0; i < 2; i++) run_frame(2);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
